// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
// Optional glitch filter is enabled by defining PWM_CAPTURE_FILTER_EN.
package pwm_pkg;

    localparam int DEFAULT_RESOLUTION = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_cap_state_t;

    // Saturation value of a cnt_w-bit counter; reaching it means no edge arrived in time.
    function automatic int unsigned timeout_cycles(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizer, optional stability filter (PWM_CAPTURE_FILTER_EN) and edge detector.
// level is the clean input level; rise/fall are single-cycle pulses derived from it.
module pwm_edge_sync #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic level_w;

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("pwm_edge_sync: FILTER_LEN must be at least 1");
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [FW-1:0] stable_q;
    logic          filt_q;

    // Follow the synchronized level only after it has differed for FILTER_LEN samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= '0;
            filt_q   <= 1'b0;
        end else if (sync2_q == filt_q) begin
            stable_q <= '0;
        end else if (stable_q == FW'(FILTER_LEN - 1)) begin
            stable_q <= '0;
            filt_q   <= sync2_q;
        end else begin
            stable_q <= stable_q + 1'b1;
        end
    end

    assign level_w = filt_q;
`else
    assign level_w = sync2_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_w;
        end
    end

    assign level = level_w;
    assign rise  = level_w & ~prev_q;
    assign fall  = ~level_w & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM input in clk cycles.
// Define PWM_CAPTURE_FILTER_EN to insert the glitch filter ahead of edge detection.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int RESOLUTION = DEFAULT_RESOLUTION,
    parameter int CNT_W      = RESOLUTION + 2,
    parameter int FILTER_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty_count,
    output logic [CNT_W-1:0] period_count,
    output logic             meas_valid,
    output logic             no_signal,
    output logic             stuck_level
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(timeout_cycles(CNT_W));

    pwm_cap_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_tmp_q, duty_tmp_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             no_sig_q, no_sig_d;
    logic             stuck_q, stuck_d;

    logic level;
    logic rise;
    logic fall;
    logic timeout;
    logic close_meas;

    pwm_edge_sync #(
        .FILTER_LEN(FILTER_LEN)
    ) u_edge_sync (
        .clk   (clk),
        .rst   (rst),
        .pwm_in(pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // Once flagged, an idle saturated counter must not re-trigger and overwrite stuck_level.
    assign timeout    = (cnt_q == CNT_MAX) && ((state_q != IDLE) || !no_sig_q);
    assign close_meas = rise && (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (rise) state_d = HIGH;
                HIGH:    if (fall) state_d = LOW;
                LOW:     if (rise) state_d = HIGH;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d      = rise ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
        duty_tmp_d = duty_tmp_q;
        duty_d     = duty_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        no_sig_d   = no_sig_q;
        stuck_d    = stuck_q;
        if (timeout) begin
            no_sig_d = 1'b1;
            stuck_d  = level;
            duty_d   = '0;
            period_d = '0;
        end else begin
            if ((state_q == HIGH) && fall) begin
                duty_tmp_d = cnt_q + 1'b1;
            end
            // A rise while HIGH means a missed fall; it still closes the period.
            if (close_meas) begin
                duty_d   = duty_tmp_q;
                period_d = cnt_q + 1'b1;
                valid_d  = 1'b1;
                no_sig_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            duty_tmp_q <= '0;
            duty_q     <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            no_sig_q   <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            duty_tmp_q <= duty_tmp_d;
            duty_q     <= duty_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            no_sig_q   <= no_sig_d;
            stuck_q    <= stuck_d;
        end
    end

    assign duty_count   = duty_q;
    assign period_count = period_q;
    assign meas_valid   = valid_q;
    assign no_signal    = no_sig_q;
    assign stuck_level  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture; expectations follow the filter build (PWM_CAPTURE_FILTER_EN).
module tb_pwm_capture;

    localparam int CNT_W = 12;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int SHORT_H = 5;
`else
    localparam int SHORT_H = 1;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] duty;
        logic [CNT_W-1:0] period;
    } meas_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic [CNT_W-1:0] duty_count;
    logic [CNT_W-1:0] period_count;
    logic             meas_valid;
    logic             no_signal;
    logic             stuck_level;

    meas_t q[$];
    int    errors = 0;
    int    checks = 0;

    pwm_capture #(
        .RESOLUTION(10),
        .CNT_W     (CNT_W),
        .FILTER_LEN(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .duty_count  (duty_count),
        .period_count(period_count),
        .meas_valid  (meas_valid),
        .no_signal   (no_signal),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    // Record every strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (meas_valid) begin
            meas_t m;
            m.duty   = duty_count;
            m.period = period_count;
            q.push_back(m);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_meas(input string tag, input int idx, input int d, input int p);
        if (idx < q.size()) begin
            check({tag, ".duty"}, 32'(q[idx].duty), d);
            check({tag, ".period"}, 32'(q[idx].period), p);
        end else begin
            check({tag, ".present"}, q.size(), idx + 1);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".duty"}, 32'(duty_count), 0);
        check({tag, ".period"}, 32'(period_count), 0);
        check({tag, ".valid"}, 32'(meas_valid), 0);
        check({tag, ".no_signal"}, 32'(no_signal), 0);
        check({tag, ".stuck"}, 32'(stuck_level), 0);
    endtask

    task automatic drive(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pwm_period(input int h, input int l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        drive(1'b0, 20);

        // Steady 300/724: four closed periods after the opening rise.
        q.delete();
        repeat (4) pwm_period(300, 724);
        drive(1'b1, 9);
        check("steady.count", q.size(), 4);
        for (int i = 0; i < 4; i++) check_meas($sformatf("steady[%0d]", i), i, 300, 1024);
        drive(1'b1, 291);
        drive(1'b0, 724);

        // Narrow pulse: the preceding 300/1024 period closes first.
        q.delete();
        repeat (3) pwm_period(SHORT_H, 1024 - SHORT_H);
        drive(1'b1, SHORT_H);
        drive(1'b0, 9);
        check("narrow.count", q.size(), 4);
        check_meas("narrow[0]", 0, 300, 1024);
        for (int i = 1; i < 4; i++) check_meas($sformatf("narrow[%0d]", i), i, SHORT_H, 1024);
        drive(1'b0, 1024 - SHORT_H - 9);

        // Stuck high long enough for the counter to saturate.
        q.delete();
        drive(1'b1, 5000);
        check("stuck.count", q.size(), 1);
        check("stuck.no_signal", 32'(no_signal), 1);
        check("stuck.level", 32'(stuck_level), 1);
        check("stuck.duty", 32'(duty_count), 0);
        check("stuck.period", 32'(period_count), 0);

        // Recovery: no_signal holds through the first rise and clears at the second.
        q.delete();
        drive(1'b0, 724);
        pwm_period(300, 724);
        check("resume.first_rise.no_signal", 32'(no_signal), 1);
        check("resume.first_rise.count", q.size(), 0);
        drive(1'b1, 9);
        check("resume.no_signal", 32'(no_signal), 0);
        check("resume.count", q.size(), 1);
        check_meas("resume[0]", 0, 300, 1024);
        drive(1'b1, 291);
        drive(1'b0, 724);

        // Duty change 300 -> 700 with no intermediate value.
        q.delete();
        repeat (2) pwm_period(700, 324);
        drive(1'b1, 9);
        check("dchange.count", q.size(), 3);
        check_meas("dchange[0]", 0, 300, 1024);
        check_meas("dchange[1]", 1, 700, 1024);
        check_meas("dchange[2]", 2, 700, 1024);
        drive(1'b1, 291);
        drive(1'b0, 724);

        // One-cycle low glitch at cycle 100 of a 300-cycle high phase.
        q.delete();
        drive(1'b1, 100);
        drive(1'b0, 1);
        drive(1'b1, 199);
        drive(1'b0, 724);
        drive(1'b1, 9);
`ifdef PWM_CAPTURE_FILTER_EN
        check("glitch.count", q.size(), 2);
        check_meas("glitch[0]", 0, 300, 1024);
        check_meas("glitch[1]", 1, 300, 1024);
`else
        check("glitch.count", q.size(), 3);
        check_meas("glitch[0]", 0, 300, 1024);
        check_meas("glitch[1]", 1, 100, 101);
        check_meas("glitch[2]", 2, 199, 923);
`endif
        drive(1'b1, 291);

        // Reset mid-period during the low phase; two rises are needed for the next strobe.
        drive(1'b0, 300);
        rst = 1'b1;
        drive(1'b0, 10);
        check_outputs_zero("midreset");
        rst = 1'b0;
        q.delete();
        drive(1'b0, 414);
        pwm_period(300, 724);
        check("midreset.first_rise.count", q.size(), 0);
        drive(1'b1, 9);
        check("midreset.second_rise.count", q.size(), 1);
        check_meas("midreset[0]", 0, 300, 1024);
        drive(1'b1, 291);
        drive(1'b0, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
